pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Sequencing controller for the 5-stage ARM pipeline front end. It drives the program counter enable, the IF/ID enable and flush, and the control-unit mux select that injects NOP bubbles into ID/EX. It resolves load-use hazards, taken-branch flushes, post-reset startup and debug halt/single-step, and it counts bubble cycles for performance monitoring.

Parameters:
STARTUP_CYCLES, 2, cycles the front end is held after reset deasserts (>=1)
LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (>=1, <=15)
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ex_mem_read  input  1  instruction in EX is a load (ID/EX mem_to_reg_select)
ex_rd  input  4  destination register of the instruction in EX
id_rn  input  4  Rn field of the instruction in IF/ID
id_rm  input  4  Rm field of the instruction in IF/ID
id_rn_used  input  1  ID instruction reads Rn
id_rm_used  input  1  ID instruction reads Rm
branch_taken  input  1  control unit pc_source_select, resolved in ID
debug_halt  input  1  level request to halt issue
step_pulse  input  1  one-cycle request to issue one instruction while halted
pc_enable  output  1  program counter load enable
if_id_enable  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID loads all-zero NOP on the next edge
cu_mux_select  output  1  1 = CU mux forwards all-zero controls (bubble), 0 = pass through
stall_count  output  CNT_W  saturating count of bubble cycles
state_out  output  3  current FSM state encoding

Behaviour:
- FSM states and encodings: STARTUP=0, RUN=1, LU_STALL=2, BR_FLUSH=3, HALT=4, STEP=5. The state and both counters are registered.
- Outputs are combinational from the current state and the hazard inputs. Zero added latency on hazards.
- load_use = ex_mem_read & (ex_rd != 4'd15) & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)).
- Reset (async, any time, including mid-stall):
  - state=STARTUP, startup counter=STARTUP_CYCLES-1, stall counter=0, stall_count=0.
  - While reset is high: pc_enable=0, if_id_enable=0, if_id_flush=0, cu_mux_select=1.
- STARTUP:
  - Outputs as under reset.
  - The counter decrements each edge. When it reaches 0, go to RUN.
  - Total hold is exactly STARTUP_CYCLES edges after reset deasserts.
- RUN, and STEP, which uses identical output and hazard rules. Priority is load_use > branch_taken > debug_halt.
  - load_use:
    - Outputs: pc_enable=0, if_id_enable=0, cu_mux_select=1, if_id_flush=0.
    - If LOAD_STALL_CYCLES==1, the next state is RUN (or HALT per the exit rule).
    - Otherwise go to LU_STALL with the stall counter = LOAD_STALL_CYCLES-2.
  - branch_taken (no load_use):
    - Outputs: pc_enable=1, if_id_enable=1, if_id_flush=1, cu_mux_select=0. The branch itself proceeds, so BL still writes LR.
    - Next state is BR_FLUSH.
  - Neither hazard:
    - Outputs: pc_enable=1, if_id_enable=1, cu_mux_select=0, if_id_flush=0.
    - In RUN, the next state is HALT if debug_halt, else RUN.
    - In STEP, the next state is HALT if debug_halt, else RUN.
- LU_STALL:
  - Outputs as in a load-use cycle.
  - load_use and branch_taken are ignored.
  - The counter decrements each edge. At 0, apply the exit rule.
- BR_FLUSH (exactly 1 cycle):
  - Outputs: pc_enable=1, if_id_enable=1, cu_mux_select=1, if_id_flush=0.
  - The flushed NOP in ID is bubbled. branch_taken and load_use are ignored.
  - Then apply the exit rule.
- Exit rule (end of LU_STALL, BR_FLUSH, or a hazard raised in STEP): next = debug_halt ? HALT : RUN.
- HALT:
  - Outputs: pc_enable=0, if_id_enable=0, cu_mux_select=1, if_id_flush=0.
  - If debug_halt drops, go to RUN on the next edge.
  - Otherwise step_pulse goes to STEP. step_pulse outside HALT is ignored.
  - If debug_halt and step_pulse are both asserted, STEP is taken.
- stall_count:
  - Increments on each edge where cu_mux_select=1 and state != STARTUP.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- A debug_halt assertion while a hazard is being resolved is deferred until the hazard completes. A hazard is never cut short.

Test Plan:
- Reset high for 3 time units, then low, with STARTUP_CYCLES=2 -> pc_enable=0 and cu_mux_select=1 for 2 edges; state_out=1 on the 3rd; PC advances by 4 per cycle afterwards; stall_count=0.
- LDRB r2,[r1] followed by ADD using r2 as Rm (ex_mem_read=1, ex_rd=2, id_rm=2, id_rm_used=1) -> one cycle with pc_enable=0, if_id_enable=0, cu_mux_select=1; ID/EX RegWrite=0 next edge; stall_count=1. Repeat with LOAD_STALL_CYCLES=3 -> 3 bubble cycles, state_out=2 for 2 of them, stall_count=3.
- Same load with ex_rd=15, or with a matching register but id_rm_used=0 -> no stall; state stays 1.
- BNE taken (branch_taken=1) -> if_id_flush=1 for one cycle, then state 3 with cu_mux_select=1 for one cycle, back to state 1; branch_taken held high during BR_FLUSH causes no second flush; stall_count +1.
- debug_halt=1 in RUN -> state 4 next edge, PC frozen; one step_pulse -> exactly one PC increment of 4 (state 5 for one cycle), then back to state 4; debug_halt=0 -> RUN next edge.
- Drive reset high in the middle of LU_STALL -> outputs go to reset values immediately, without waiting for clk; stall_count=0; STARTUP sequence repeats. Separately, force 2^CNT_W+5 bubble cycles -> stall_count holds 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Front-end sequencing controller for the 5-stage pipeline: PC / IF-ID enables,
// IF-ID flush and CU bubble select for load-use, taken-branch, startup and debug halt/step.
module pipeline_hazard_controller #(
    parameter int STARTUP_CYCLES    = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_rd,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             branch_taken,
    input  logic             debug_halt,
    input  logic             step_pulse,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             cu_mux_select,
    output logic [CNT_W-1:0] stall_count,
    output logic [2:0]       state_out
);

    typedef enum logic [2:0] {
        ST_STARTUP  = 3'd0,
        ST_RUN      = 3'd1,
        ST_LU_STALL = 3'd2,
        ST_BR_FLUSH = 3'd3,
        ST_HALT     = 3'd4,
        ST_STEP     = 3'd5
    } state_e;

    localparam int              SU_W    = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SU_W-1:0] SU_INIT = SU_W'(STARTUP_CYCLES - 1);
    // The first bubble is the RUN/STEP cycle that detects the hazard, so LU_STALL covers the rest.
    localparam logic [3:0]      LU_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_e           state_q, state_d;
    logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
    logic [3:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             load_use;
    state_e           exit_state;

    assign load_use = ex_mem_read && (ex_rd != 4'd15) &&
                      ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));

    // A halt request raised mid-hazard is only honoured here, once the hazard has finished.
    assign exit_state = debug_halt ? ST_HALT : ST_RUN;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_STARTUP;
            su_cnt_q      <= SU_INIT;
            lu_cnt_q      <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            su_cnt_q      <= su_cnt_d;
            lu_cnt_q      <= lu_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        lu_cnt_d = lu_cnt_q;
        case (state_q)
            ST_STARTUP: begin
                if (su_cnt_q == '0) state_d = ST_RUN;
                else                su_cnt_d = su_cnt_q - SU_W'(1);
            end
            ST_RUN, ST_STEP: begin
                if (load_use) begin
                    if (LOAD_STALL_CYCLES == 1) begin
                        state_d = exit_state;
                    end else begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_INIT;
                    end
                end else if (branch_taken) begin
                    state_d = ST_BR_FLUSH;
                end else begin
                    state_d = exit_state;
                end
            end
            ST_LU_STALL: begin
                if (lu_cnt_q == 4'd0) state_d = exit_state;
                else                  lu_cnt_d = lu_cnt_q - 4'd1;
            end
            ST_BR_FLUSH: state_d = exit_state;
            ST_HALT: begin
                if (!debug_halt)     state_d = ST_RUN;
                else if (step_pulse) state_d = ST_STEP;
            end
            default: state_d = exit_state;
        endcase
    end

    // Any state not issuing freezes the front end and bubbles ID/EX; reset lands in STARTUP.
    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        cu_mux_select = 1'b1;
        case (state_q)
            ST_RUN, ST_STEP: begin
                if (!load_use) begin
                    pc_enable     = 1'b1;
                    if_id_enable  = 1'b1;
                    cu_mux_select = 1'b0;
                    if_id_flush   = branch_taken;
                end
            end
            ST_BR_FLUSH: begin
                pc_enable    = 1'b1;
                if_id_enable = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (cu_mux_select && (state_q != ST_STARTUP) && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    assign stall_count = stall_count_q;
    assign state_out   = state_q;

endmodule
